// File: rtl/booth_mac_pkg.sv
// Shared definitions for the Booth multiply-accumulate slice: FSM state encoding
// and default widths, also used for the multiplier result bus.
package booth_mac_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ACC_WIDTH  = 24;
   localparam int DEFAULT_LEN_WIDTH  = 8;
   localparam int DEFAULT_PROD_WIDTH = 2 * DEFAULT_DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      HOLD  = 2'b10
   } mac_state_t;

endpackage

// File: rtl/booth_mac_adder.sv
// Combinational accumulator adder with carry-out; clamps to all ones on carry
// when BOOTH_MAC_SATURATE_EN is defined, otherwise wraps.
module booth_mac_adder
   import booth_mac_pkg::*;
#(
   parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
   input  logic [ACC_WIDTH-1:0] i_a,
   input  logic [ACC_WIDTH-1:0] i_b,
   output logic [ACC_WIDTH-1:0] o_sum,
   output logic                 o_carry
);

   logic [ACC_WIDTH:0] w_full;

   assign w_full  = {1'b0, i_a} + {1'b0, i_b};
   assign o_carry = w_full[ACC_WIDTH];

`ifdef BOOTH_MAC_SATURATE_EN
   // Once clamped, further adds keep carrying (or add zero), so the value stays pinned.
   assign o_sum = w_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
`else
   assign o_sum = w_full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates a programmed number of Booth multiplier products and presents the sum
// on a valid/ready port. Optional saturation: define BOOTH_MAC_SATURATE_EN.
module booth_mac_accum
   import booth_mac_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
   parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
   input  logic                    clk_i_mult,
   input  logic                    rstn_i_mult,
   input  logic                    start_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   input  logic [2*DATA_WIDTH-1:0] prod_i,
   input  logic                    prod_done_i,
   output logic                    busy_o,
   output logic [LEN_WIDTH-1:0]    count_o,
   output logic [ACC_WIDTH-1:0]    sum_o,
   output logic                    sum_valid_o,
   input  logic                    sum_ready_i,
   output logic                    ovf_o,
   output logic                    drop_o
);

   mac_state_t r_state;
   mac_state_t w_stateNext;

   logic [LEN_WIDTH-1:0] r_len;
   logic [LEN_WIDTH-1:0] r_count;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic                 r_drop;

   logic [LEN_WIDTH-1:0] w_countNext;
   logic [ACC_WIDTH-1:0] w_addSum;
   logic                 w_addCarry;

   assign w_countNext = r_count + LEN_WIDTH'(1);

   booth_mac_adder #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_adder (
      .i_a     (r_acc),
      .i_b     (ACC_WIDTH'(prod_i)),
      .o_sum   (w_addSum),
      .o_carry (w_addCarry)
   );

   always_ff @(posedge clk_i_mult or posedge rstn_i_mult) begin
      if (rstn_i_mult) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_stateNext = (len_i == '0) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (prod_done_i && (w_countNext == r_len)) begin
               w_stateNext = HOLD;
            end
         end
         HOLD: begin
            if (sum_ready_i) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Start clears the run context; strobes seen outside ACCUM only raise the sticky drop flag.
   always_ff @(posedge clk_i_mult or posedge rstn_i_mult) begin
      if (rstn_i_mult) begin
         r_len   <= '0;
         r_count <= '0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_len   <= len_i;
                  r_count <= '0;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_drop  <= 1'b0;
               end else if (prod_done_i) begin
                  r_drop <= 1'b1;
               end
            end
            ACCUM: begin
               if (prod_done_i) begin
                  r_acc   <= w_addSum;
                  r_count <= w_countNext;
                  if (w_addCarry) begin
                     r_ovf <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (prod_done_i) begin
                  r_drop <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o      = (r_state == ACCUM) || (r_state == HOLD);
   assign sum_valid_o = (r_state == HOLD);
   assign count_o     = r_count;
   assign sum_o       = r_acc;
   assign ovf_o       = r_ovf;
   assign drop_o      = r_drop;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed self-checking bench for booth_mac_accum: a 24-bit accumulator instance
// plus a 16-bit instance for the carry/saturation case.
module tb_booth_mac_accum;

   logic        clock;
   logic        reset;

   logic        start;
   logic [7:0]  len;
   logic [15:0] prod;
   logic        prodDone;
   logic        sumReady;
   logic        busy;
   logic [7:0]  count;
   logic [23:0] sum;
   logic        sumValid;
   logic        ovf;
   logic        drop;

   logic        start16;
   logic [7:0]  len16;
   logic [15:0] prod16;
   logic        prodDone16;
   logic        sumReady16;
   logic        busy16;
   logic [7:0]  count16;
   logic [15:0] sum16;
   logic        sumValid16;
   logic        ovf16;
   logic        drop16;

   int checkCount;
   int errorCount;

   booth_mac_accum #(
      .DATA_WIDTH (8),
      .ACC_WIDTH  (24),
      .LEN_WIDTH  (8)
   ) u_dut (
      .clk_i_mult  (clock),
      .rstn_i_mult (reset),
      .start_i     (start),
      .len_i       (len),
      .prod_i      (prod),
      .prod_done_i (prodDone),
      .busy_o      (busy),
      .count_o     (count),
      .sum_o       (sum),
      .sum_valid_o (sumValid),
      .sum_ready_i (sumReady),
      .ovf_o       (ovf),
      .drop_o      (drop)
   );

   booth_mac_accum #(
      .DATA_WIDTH (8),
      .ACC_WIDTH  (16),
      .LEN_WIDTH  (8)
   ) u_dut16 (
      .clk_i_mult  (clock),
      .rstn_i_mult (reset),
      .start_i     (start16),
      .len_i       (len16),
      .prod_i      (prod16),
      .prod_done_i (prodDone16),
      .busy_o      (busy16),
      .count_o     (count16),
      .sum_o       (sum16),
      .sum_valid_o (sumValid16),
      .sum_ready_i (sumReady16),
      .ovf_o       (ovf16),
      .drop_o      (drop16)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just after the edge, where inputs change and outputs are read.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle product strobe on the 24-bit instance.
   task automatic applyStimulus(input logic [15:0] value);
      prod     = value;
      prodDone = 1'b1;
      tick();
      prodDone = 1'b0;
   endtask

   task automatic startRun(input logic [7:0] n);
      start = 1'b1;
      len   = n;
      tick();
      start = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset      = 1'b1;
      start      = 1'b0;
      len        = '0;
      prod       = '0;
      prodDone   = 1'b0;
      sumReady   = 1'b0;
      start16    = 1'b0;
      len16      = '0;
      prod16     = '0;
      prodDone16 = 1'b0;
      sumReady16 = 1'b0;

      tick();
      tick();
      checkOutput("rst_busy",  32'(busy),     32'd0);
      checkOutput("rst_valid", 32'(sumValid), 32'd0);
      checkOutput("rst_sum",   32'(sum),      32'd0);
      checkOutput("rst_count", 32'(count),    32'd0);
      checkOutput("rst_flags", 32'({ovf, drop}), 32'd0);
      reset = 1'b0;
      tick();

      // Test 1: three products summed
      startRun(8'd3);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      applyStimulus(16'd10);
      checkOutput("t1_count1", 32'(count), 32'd1);
      tick();
      checkOutput("t1_sum_idlecycle", 32'(sum), 32'd10);
      applyStimulus(16'd20);
      checkOutput("t1_valid_early", 32'(sumValid), 32'd0);
      applyStimulus(16'd30);
      checkOutput("t1_valid", 32'(sumValid), 32'd1);
      checkOutput("t1_sum",   32'(sum),      32'd60);
      checkOutput("t1_count", 32'(count),    32'd3);
      checkOutput("t1_ovf",   32'(ovf),      32'd0);
      sumReady = 1'b1;
      tick();
      sumReady = 1'b0;
      checkOutput("t1_valid_drop", 32'(sumValid), 32'd0);
      checkOutput("t1_idle_busy",  32'(busy),     32'd0);

      // Test 2: zero-length run
      startRun(8'd0);
      checkOutput("t2_valid", 32'(sumValid), 32'd1);
      checkOutput("t2_sum",   32'(sum),      32'd0);
      checkOutput("t2_count", 32'(count),    32'd0);
      sumReady = 1'b1;
      tick();
      sumReady = 1'b0;
      checkOutput("t2_valid_drop", 32'(sumValid), 32'd0);

      // Test 3: backpressure and a dropped strobe in HOLD
      startRun(8'd1);
      applyStimulus(16'hFFFF);
      checkOutput("t3_sum", 32'(sum), 32'h00FFFF);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            applyStimulus(16'h1234);
         end else begin
            tick();
         end
      end
      checkOutput("t3_sum_held",   32'(sum),      32'h00FFFF);
      checkOutput("t3_valid_held", 32'(sumValid), 32'd1);
      checkOutput("t3_drop",       32'(drop),     32'd1);
      checkOutput("t3_count",      32'(count),    32'd1);
      sumReady = 1'b1;
      tick();
      sumReady = 1'b0;
      checkOutput("t3_valid_drop", 32'(sumValid), 32'd0);
      checkOutput("t3_drop_sticky", 32'(drop),    32'd1);

      // Test 4: carry on the 16-bit accumulator
      start16 = 1'b1;
      len16   = 8'd2;
      tick();
      start16    = 1'b0;
      prodDone16 = 1'b1;
      prod16     = 16'hFFFF;
      tick();
      prod16     = 16'h0002;
      tick();
      prodDone16 = 1'b0;
      checkOutput("t4_valid", 32'(sumValid16), 32'd1);
`ifdef BOOTH_MAC_SATURATE_EN
      checkOutput("t4_sum", 32'(sum16), 32'h0000FFFF);
`else
      checkOutput("t4_sum", 32'(sum16), 32'h00000001);
`endif
      checkOutput("t4_ovf", 32'(ovf16), 32'd1);
      sumReady16 = 1'b1;
      tick();
      sumReady16 = 1'b0;

      // Test 5: reset mid-run, then a fresh run; start also clears drop
      startRun(8'd4);
      checkOutput("t5_drop_cleared", 32'(drop), 32'd0);
      applyStimulus(16'd5);
      applyStimulus(16'd6);
      checkOutput("t5_count2", 32'(count), 32'd2);
      checkOutput("t5_sum2",   32'(sum),   32'd11);
      reset = 1'b1;
      #1;
      checkOutput("t5_rst_busy",  32'(busy),     32'd0);
      checkOutput("t5_rst_sum",   32'(sum),      32'd0);
      checkOutput("t5_rst_count", 32'(count),    32'd0);
      checkOutput("t5_rst_valid", 32'(sumValid), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      startRun(8'd1);
      applyStimulus(16'd7);
      checkOutput("t5_sum",   32'(sum),      32'd7);
      checkOutput("t5_valid", 32'(sumValid), 32'd1);

      // Test 6: start during handshake ignored, next-cycle start accepted
      sumReady = 1'b1;
      start    = 1'b1;
      len      = 8'd2;
      tick();
      sumReady = 1'b0;
      checkOutput("t6_ignored_busy",  32'(busy),     32'd0);
      checkOutput("t6_ignored_valid", 32'(sumValid), 32'd0);
      checkOutput("t6_ignored_sum",   32'(sum),      32'd7);
      tick();
      start = 1'b0;
      checkOutput("t6_accept_busy", 32'(busy),     32'd1);
      checkOutput("t6_accept_sum",  32'(sum),      32'd0);
      checkOutput("t6_accept_valid", 32'(sumValid), 32'd0);
      applyStimulus(16'd3);
      applyStimulus(16'd4);
      checkOutput("t6_sum",   32'(sum),      32'd7);
      checkOutput("t6_valid", 32'(sumValid), 32'd1);
      checkOutput("t6_count", 32'(count),    32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
